// File: rtl/mem_arbiter_rr_if.sv
// mem_arbiter_rr_if: four-channel valid/ready memory bus with one handshake lane per master.
interface mem_arbiter_rr_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int RESP_WIDTH = 2,
  parameter int N = 1
);
  logic [N-1:0] r_request_valid, r_request_ready;
  logic [N-1:0][ADDR_WIDTH-1:0] r_request_raddr;
  logic [N-1:0] r_reply_valid, r_reply_ready;
  logic [DATA_WIDTH-1:0] r_reply_rdata;
  logic [RESP_WIDTH-1:0] r_reply_rresp;
  logic [N-1:0] w_request_valid, w_request_ready;
  logic [N-1:0][ADDR_WIDTH-1:0] w_request_waddr;
  logic [N-1:0][DATA_WIDTH-1:0] w_request_wdata;
  logic [N-1:0][DATA_WIDTH/8-1:0] w_request_wmask;
  logic [N-1:0] w_reply_valid, w_reply_ready;
  logic [RESP_WIDTH-1:0] w_reply_bresp;
  modport master (
    output r_request_valid, r_request_raddr, r_reply_ready,
           w_request_valid, w_request_waddr, w_request_wdata, w_request_wmask, w_reply_ready,
    input  r_request_ready, r_reply_valid, r_reply_rdata, r_reply_rresp,
           w_request_ready, w_reply_valid, w_reply_bresp
  );
  modport slave (
    input  r_request_valid, r_request_raddr, r_reply_ready,
           w_request_valid, w_request_waddr, w_request_wdata, w_request_wmask, w_reply_ready,
    output r_request_ready, r_reply_valid, r_reply_rdata, r_reply_rresp,
           w_request_ready, w_reply_valid, w_reply_bresp
  );
endinterface

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: N-to-1 memory arbiter, independent round-robin read/write paths with reply-routing ID FIFOs.
module mem_arbiter_rr_path #(
  parameter int N = 4,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_valid,
  output logic [N-1:0]         req_ready,
  output logic [$clog2(N)-1:0] grant,
  output logic                 s_req_valid,
  input  logic                 s_req_ready,
  output logic [N-1:0]         rep_valid,
  input  logic [N-1:0]         rep_ready,
  input  logic                 s_rep_valid,
  output logic                 s_rep_ready
);
  localparam int IW = $clog2(N);
  localparam int PW = $clog2(DEPTH);
  logic [IW-1:0] rr_ptr, lock_idx, head;
  logic [IW-1:0] fifo [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  logic lock, full, empty, push, pop;
  // scanning downward lets the lowest offset from rr_ptr win
  always_comb begin
    grant = rr_ptr;
    for (int i = N - 1; i >= 0; i--) begin
      logic [IW-1:0] idx;
      idx = IW'((int'(rr_ptr) + i) % N);
      grant = req_valid[idx] ? idx : grant;
    end
    grant = lock ? lock_idx : grant;
  end
  assign full = count == (PW+1)'(DEPTH);
  assign empty = count == '0;
  assign head = fifo[rd_ptr];
  assign s_req_valid = !rst && !full && req_valid[grant];
  assign req_ready = (!rst && !full && s_req_ready) ? N'(1) << grant : '0;
  assign rep_valid = (!rst && !empty && s_rep_valid) ? N'(1) << head : '0;
  assign s_rep_ready = !rst && !empty && rep_ready[head];
  assign push = s_req_valid && s_req_ready;
  assign pop = s_rep_valid && s_rep_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      lock <= 1'b0;
      lock_idx <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= grant;
        wr_ptr <= wr_ptr + 1'b1;
        rr_ptr <= IW'((int'(grant) + 1) % N);
        lock <= 1'b0;
      end else if (s_req_valid) begin
        lock <= 1'b1;
        lock_idx <= grant;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
endmodule

module mem_arbiter_rr #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int RESP_WIDTH = 2,
  parameter int N = 4,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  mem_arbiter_rr_if.slave m,
  mem_arbiter_rr_if.master s
);
  logic [$clog2(N)-1:0] r_grant, w_grant;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr;
  logic [DATA_WIDTH-1:0] w_data, rdata;
  logic [DATA_WIDTH/8-1:0] w_mask;
  logic [RESP_WIDTH-1:0] rresp, bresp;
  mem_arbiter_rr_path #(.N(N), .DEPTH(DEPTH)) r_path (
    .clk(clk), .rst(rst),
    .req_valid(m.r_request_valid), .req_ready(m.r_request_ready), .grant(r_grant),
    .s_req_valid(s.r_request_valid[0]), .s_req_ready(s.r_request_ready[0]),
    .rep_valid(m.r_reply_valid), .rep_ready(m.r_reply_ready),
    .s_rep_valid(s.r_reply_valid[0]), .s_rep_ready(s.r_reply_ready[0])
  );
  mem_arbiter_rr_path #(.N(N), .DEPTH(DEPTH)) w_path (
    .clk(clk), .rst(rst),
    .req_valid(m.w_request_valid), .req_ready(m.w_request_ready), .grant(w_grant),
    .s_req_valid(s.w_request_valid[0]), .s_req_ready(s.w_request_ready[0]),
    .rep_valid(m.w_reply_valid), .rep_ready(m.w_reply_ready),
    .s_rep_valid(s.w_reply_valid[0]), .s_rep_ready(s.w_reply_ready[0])
  );
  assign r_addr = m.r_request_raddr[r_grant];
  assign w_addr = m.w_request_waddr[w_grant];
  assign w_data = m.w_request_wdata[w_grant];
  assign w_mask = m.w_request_wmask[w_grant];
  assign s.r_request_raddr[0] = r_addr;
  assign s.w_request_waddr[0] = w_addr;
  assign s.w_request_wdata[0] = w_data;
  assign s.w_request_wmask[0] = w_mask;
  assign rdata = s.r_reply_rdata;
  assign rresp = s.r_reply_rresp;
  assign bresp = s.w_reply_bresp;
  assign m.r_reply_rdata = rdata;
  assign m.r_reply_rresp = rresp;
  assign m.w_reply_bresp = bresp;
endmodule
